// File: rtl/rgb_byte_unpacker.sv
// rgb_byte_unpacker: reassembles an R,G,B byte stream into 24-bit pixels tagged
// with raster coordinates and frame markers, presented on a registered
// valid/ready output.
module rgb_byte_unpacker #(
    parameter  int WIDTH  = 610,
    parameter  int HEIGHT = 874,
    localparam int XW     = $clog2(WIDTH),
    localparam int YW     = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sync,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [23:0]   m_pixel,
    output logic [XW-1:0] m_x,
    output logic [YW-1:0] m_y,
    output logic          m_sof,
    output logic          m_eol,
    output logic          m_eof,
    output logic [15:0]   frame_cnt
);

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    phase_t          phase, phase_nxt;
    logic            accept;
    logic            pix_fire;
    logic [7:0]      r_byte_p0;
    logic [7:0]      g_byte_p0;
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    logic            x_last;
    logic            y_last;

    assign x_last = (x_cnt == XW'(WIDTH - 1));
    assign y_last = (y_cnt == YW'(HEIGHT - 1));

    // Byte phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_R;
        end else begin
            phase <= phase_nxt;
        end
    end

    // Next phase, input ready and pixel-complete decode; only the B byte can be
    // held off, and only while the output register is full and not draining.
    always_comb begin
        phase_nxt = phase;
        s_ready   = 1'b1;
        pix_fire  = 1'b0;
        if (phase == PH_B) begin
            s_ready = !m_valid || m_ready;
        end
        accept = s_valid && s_ready;
        if (sync) begin
            // A byte accepted alongside sync is the R byte of the new frame.
            phase_nxt = accept ? PH_G : PH_R;
        end else if (accept) begin
            case (phase)
                PH_R: phase_nxt = PH_G;
                PH_G: phase_nxt = PH_B;
                PH_B: begin
                    phase_nxt = PH_R;
                    pix_fire  = 1'b1;
                end
                default: phase_nxt = PH_R;
            endcase
        end
    end

    // ---- stage p0: R/G staging ----
    // Capture R and G bytes; sync throws away any partial pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_p0 <= 8'd0;
            g_byte_p0 <= 8'd0;
        end else if (sync) begin
            r_byte_p0 <= accept ? s_data : 8'd0;
            g_byte_p0 <= 8'd0;
        end else if (accept) begin
            if (phase == PH_R) begin
                r_byte_p0 <= s_data;
            end
            if (phase == PH_G) begin
                g_byte_p0 <= s_data;
            end
        end
    end

    // Raster position of the next pixel to be emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (sync) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix_fire) begin
            if (x_last) begin
                x_cnt <= '0;
                y_cnt <= y_last ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // Completed-frame counter, bumped on the edge the last B byte is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (pix_fire && x_last && y_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // ---- stage p1: output register ----
    // Load a finished pixel with its tags; hold while stalled, empty on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pixel <= 24'd0;
            m_x     <= '0;
            m_y     <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else if (pix_fire) begin
            m_valid <= 1'b1;
            m_pixel <= {r_byte_p0, g_byte_p0, s_data};
            m_x     <= x_cnt;
            m_y     <= y_cnt;
            m_sof   <= (x_cnt == '0) && (y_cnt == '0);
            m_eol   <= x_last;
            m_eof   <= x_last && y_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rgb_byte_unpacker.sv
// Directed testbench for rgb_byte_unpacker with a 4x2 frame.
module tb_rgb_byte_unpacker;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int XW     = $clog2(WIDTH);
    localparam int YW     = $clog2(HEIGHT);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sync;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          m_valid;
    logic          m_ready;
    logic [23:0]   m_pixel;
    logic [XW-1:0] m_x;
    logic [YW-1:0] m_y;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic [15:0]   frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    rgb_byte_unpacker #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync      (sync),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_pixel   (m_pixel),
        .m_x       (m_x),
        .m_y       (m_y),
        .m_sof     (m_sof),
        .m_eol     (m_eol),
        .m_eof     (m_eof),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte from a negedge; returns on the negedge after it is accepted.
    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = b;
        #1;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] bval(input int i);
        return 8'(i * 7 + 3);
    endfunction

    initial begin
        int bi, pk, eof_cnt, cyc;
        logic held;
        logic [23:0] held_pix;
        logic [23:0] exp_pix;

        rst_n   = 1'b0;
        sync    = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        m_ready = 1'b1;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_m_pixel", 32'(m_pixel), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full frame of bytes 0x00..0x17 with the sink always ready.
        for (int k = 0; k < 8; k++) begin
            push(8'(3 * k));
            push(8'(3 * k + 1));
            push(8'(3 * k + 2));
            check("s2_valid", 32'(m_valid), 32'd1);
            check("s2_pixel", 32'(m_pixel), {8'd0, 8'(3 * k), 8'(3 * k + 1), 8'(3 * k + 2)});
            check("s2_x", 32'(m_x), 32'(k % 4));
            check("s2_y", 32'(m_y), 32'(k / 4));
            check("s2_sof", 32'(m_sof), 32'(k == 0));
            check("s2_eol", 32'(m_eol), 32'(k % 4 == 3));
            check("s2_eof", 32'(m_eof), 32'(k == 7));
            if (k == 0) check("s2_first", 32'(m_pixel), 32'h000102);
            if (k == 3) check("s2_eolpix", 32'(m_pixel), 32'h090A0B);
            if (k == 7) check("s2_last", 32'(m_pixel), 32'h151617);
        end
        s_valid = 1'b0;
        check("s2_frame_cnt", 32'(frame_cnt), 32'd1);
        @(negedge clk);
        check("s2_drained", 32'(m_valid), 32'd0);

        // Backpressure on the B byte, released without a bubble.
        push(8'h00);
        push(8'h01);
        push(8'h02);
        check("s3_pix0", 32'(m_pixel), 32'h000102);
        m_ready = 1'b0;
        push(8'h03);
        push(8'h04);
        s_data = 8'h05;
        #1;
        check("s3_stall_ready", 32'(s_ready), 32'd0);
        check("s3_hold_pix", 32'(m_pixel), 32'h000102);
        @(negedge clk);
        #1;
        check("s3_stall_ready2", 32'(s_ready), 32'd0);
        check("s3_hold_pix2", 32'(m_pixel), 32'h000102);
        check("s3_hold_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        #1;
        check("s3_release_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        check("s3_next_valid", 32'(m_valid), 32'd1);
        check("s3_next_pix", 32'(m_pixel), 32'h030405);
        check("s3_next_x", 32'(m_x), 32'd1);
        @(negedge clk);
        check("s3_empty", 32'(m_valid), 32'd0);

        // Resync with a byte on the same edge: that byte becomes R at (0,0).
        push(8'hAA);
        push(8'hBB);
        sync    = 1'b1;
        s_data  = 8'h11;
        s_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sync = 1'b0;
        push(8'h22);
        push(8'h33);
        check("s4_pix", 32'(m_pixel), 32'h112233);
        check("s4_x", 32'(m_x), 32'd0);
        check("s4_y", 32'(m_y), 32'd0);
        check("s4_sof", 32'(m_sof), 32'd1);
        check("s4_frame_cnt", 32'(frame_cnt), 32'd1);

        // Resync while the B byte is stalled: byte not taken, output kept.
        m_ready = 1'b0;
        push(8'h44);
        push(8'h55);
        s_data = 8'h66;
        #1;
        check("s4_b_stalled", 32'(s_ready), 32'd0);
        sync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sync = 1'b0;
        #1;
        check("s4_sync_ready", 32'(s_ready), 32'd1);
        check("s4_kept_valid", 32'(m_valid), 32'd1);
        check("s4_kept_pix", 32'(m_pixel), 32'h112233);
        m_ready = 1'b1;
        push(8'h66);
        push(8'h77);
        push(8'h88);
        s_valid = 1'b0;
        check("s4_pix2", 32'(m_pixel), 32'h667788);
        check("s4_x2", 32'(m_x), 32'd0);
        check("s4_sof2", 32'(m_sof), 32'd1);

        // Asynchronous reset with a pixel held and a partial pixel staged.
        @(negedge clk);
        m_ready = 1'b0;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        s_valid = 1'b0;
        check("s1_pre_valid", 32'(m_valid), 32'd1);
        check("s1_pre_frame", 32'(frame_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s1_valid", 32'(m_valid), 32'd0);
        check("s1_ready", 32'(s_ready), 32'd1);
        check("s1_frame_cnt", 32'(frame_cnt), 32'd0);
        check("s1_pixel", 32'(m_pixel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random valid/ready over three frames against an in-order model.
        bi = 0;
        pk = 0;
        eof_cnt = 0;
        cyc = 0;
        held = 1'b0;
        held_pix = 24'd0;
        while (pk < 24 && cyc < 3000) begin
            if (held) begin
                check("s5_hold_valid", 32'(m_valid), 32'd1);
                check("s5_hold_pix", 32'(m_pixel), 32'(held_pix));
            end
            s_valid = (bi < 72) && ($urandom_range(0, 3) != 0);
            s_data  = bval(bi);
            m_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (m_valid && m_ready) begin
                exp_pix = {bval(3 * pk), bval(3 * pk + 1), bval(3 * pk + 2)};
                check("s5_pix", 32'(m_pixel), 32'(exp_pix));
                check("s5_x", 32'(m_x), 32'(pk % 4));
                check("s5_y", 32'(m_y), 32'((pk / 4) % 2));
                check("s5_eof", 32'(m_eof), 32'(pk % 8 == 7));
                if (m_eof) eof_cnt++;
                pk++;
            end
            held     = m_valid && !m_ready;
            held_pix = m_pixel;
            if (s_valid && s_ready) bi++;
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        check("s5_all_pixels", 32'(pk), 32'd24);
        check("s5_frame_cnt", 32'(frame_cnt), 32'd3);
        check("s5_eof_cnt", 32'(eof_cnt), 32'd3);
        @(negedge clk);

        // Frame counter wrap from 0xFFFF.
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        check("s6_preset", 32'(frame_cnt), 32'h0000FFFF);
        for (int i = 0; i < 21; i++) push(8'(i));
        check("s6_before_wrap", 32'(frame_cnt), 32'h0000FFFF);
        push(8'd21);
        push(8'd22);
        push(8'd23);
        s_valid = 1'b0;
        check("s6_eof", 32'(m_eof), 32'd1);
        check("s6_wrap", 32'(frame_cnt), 32'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
